// File: rtl/logic_capture_packer.sv
// Per-port logic-analyzer capture endpoint: packs sample words into wide FIFO words,
// handles end-of-capture flush of partial words and tracks dropped words.
module logic_capture_packer #(
    parameter int unsigned SAMPLE_WIDTH = 32,
    parameter int unsigned PACK_RATIO   = 4
) (
    input  logic                               clk_312p5mhz,
    input  logic                               trig_rst,
    input  logic                               capture_en,
    input  logic                               capture_flush,
    input  logic                               sample_valid,
    input  logic [SAMPLE_WIDTH-1:0]            sample_data,
    input  logic                               fifo_full,
    output logic                               fifo_wr_en,
    output logic [SAMPLE_WIDTH*PACK_RATIO-1:0] fifo_wr_data,
    output logic [2:0]                         fifo_wr_lanes,
    output logic                               flush_done,
    output logic                               overflow,
    output logic [31:0]                        sample_count
);

    localparam int unsigned WordWidth = SAMPLE_WIDTH * PACK_RATIO;
    localparam logic [1:0]  LastLane  = 2'(PACK_RATIO - 1);
    localparam logic [2:0]  FullLanes = 3'(PACK_RATIO);

    typedef enum logic [1:0] {StIdle, StCapture, StFlush, StDone} state_e;

    state_e               state_q, state_d;
    logic [1:0]           ptr_q, ptr_d;
    logic [WordWidth-1:0] pack_q, pack_d;

    logic                 accept;
    logic                 wr_req;
    logic                 flush_pulse;
    logic [WordWidth-1:0] wr_word;
    logic [WordWidth-1:0] word_ins;
    logic [2:0]           wr_lanes;
    logic [32:0]          count_sum;
    logic [31:0]          count_next;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        pack_d      = pack_q;
        accept      = 1'b0;
        wr_req      = 1'b0;
        flush_pulse = 1'b0;
        wr_word     = pack_q;
        wr_lanes    = FullLanes;
        word_ins    = pack_q;

        unique case (state_q)
            StIdle: begin
                if (capture_en) begin
                    state_d = StCapture;
                    accept  = sample_valid;
                end
            end
            StCapture: begin
                accept = capture_en && sample_valid;
                if (capture_flush) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                // Pack register is kept zero above ptr, so unused lanes go out as 0.
                if (ptr_q != 2'd0) begin
                    wr_req   = 1'b1;
                    wr_lanes = {1'b0, ptr_q};
                end
                flush_pulse = 1'b1;
                ptr_d       = 2'd0;
                pack_d      = '0;
                state_d     = StDone;
            end
            StDone: begin
                if (!capture_en) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        for (int i = 0; i < PACK_RATIO; i++) begin
            if (ptr_q == 2'(i)) begin
                word_ins[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] = sample_data;
            end
        end

        if (accept) begin
            if (ptr_q == LastLane) begin
                wr_req   = 1'b1;
                wr_word  = word_ins;
                wr_lanes = FullLanes;
                ptr_d    = 2'd0;
                pack_d   = '0;
            end else begin
                ptr_d  = ptr_q + 2'd1;
                pack_d = word_ins;
            end
        end
    end

    assign count_sum  = {1'b0, sample_count} + {30'd0, fifo_wr_lanes};
    assign count_next = count_sum[32] ? 32'hFFFF_FFFF : count_sum[31:0];

    always_ff @(posedge clk_312p5mhz) begin
        if (trig_rst) begin
            state_q       <= StIdle;
            ptr_q         <= 2'd0;
            pack_q        <= '0;
            fifo_wr_en    <= 1'b0;
            fifo_wr_data  <= '0;
            fifo_wr_lanes <= 3'd0;
            flush_done    <= 1'b0;
            overflow      <= 1'b0;
            sample_count  <= 32'd0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            pack_q     <= pack_d;
            fifo_wr_en <= wr_req && !fifo_full;
            flush_done <= flush_pulse;
            if (wr_req && !fifo_full) begin
                fifo_wr_data  <= wr_word;
                fifo_wr_lanes <= wr_lanes;
            end
            if (wr_req && fifo_full) begin
                overflow <= 1'b1;
            end
            if (fifo_wr_en) begin
                sample_count <= count_next;
            end
        end
    end

endmodule

// File: tb/tb_logic_capture_packer.sv
// Randomized bench for logic_capture_packer against a sample-queue reference model,
// plus the directed capture scenarios.
module tb_logic_capture_packer;

    logic         clk_312p5mhz;
    logic         trig_rst;
    logic         capture_en;
    logic         capture_flush;
    logic         sample_valid;
    logic [31:0]  sample_data;
    logic         fifo_full;
    logic         fifo_wr_en;
    logic [127:0] fifo_wr_data;
    logic [2:0]   fifo_wr_lanes;
    logic         flush_done;
    logic         overflow;
    logic [31:0]  sample_count;

    logic_capture_packer #(
        .SAMPLE_WIDTH(32),
        .PACK_RATIO  (4)
    ) dut (
        .clk_312p5mhz (clk_312p5mhz),
        .trig_rst     (trig_rst),
        .capture_en   (capture_en),
        .capture_flush(capture_flush),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_wr_lanes(fifo_wr_lanes),
        .flush_done   (flush_done),
        .overflow     (overflow),
        .sample_count (sample_count)
    );

    initial begin
        clk_312p5mhz = 1'b0;
        forever #2 clk_312p5mhz = ~clk_312p5mhz;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int edge_no  = 0;

    // Reference model: 0 idle, 1 capturing, 2 flushing, 3 done.
    int            phase;
    logic [31:0]   pend[$];
    logic [159:0]  exp_wr[$];
    logic [159:0]  got_wr[$];
    logic [31:0]   exp_fd[$];
    logic [31:0]   got_fd[$];
    logic [31:0]   exp_count;
    logic          exp_ovf;
    logic [127:0]  last_data;
    bit            have_last;

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [159:0] mk_rec(input int e, input int lanes, input logic [127:0] d);
        return {16'(e), 13'd0, 3'(lanes), d};
    endfunction

    always @(negedge clk_312p5mhz) begin
        if (fifo_wr_en) got_wr.push_back(mk_rec(edge_no, int'(fifo_wr_lanes), fifo_wr_data));
        if (flush_done) got_fd.push_back({16'(edge_no), 15'd0, fifo_wr_en});
    end

    task automatic emit_word(input logic full, input int e, output bit done);
        logic [127:0] d;
        int lanes;
        d     = '0;
        lanes = pend.size();
        for (int i = 0; i < lanes; i++) d[i*32 +: 32] = pend[i];
        pend.delete();
        done = 1'b0;
        if (full) begin
            exp_ovf = 1'b1;
        end else begin
            exp_wr.push_back(mk_rec(e, lanes, d));
            exp_count = exp_count + 32'(lanes);
            last_data = d;
            have_last = 1'b1;
            done      = 1'b1;
        end
    endtask

    task automatic accept(input logic [31:0] d, input logic full);
        bit done;
        pend.push_back(d);
        if (pend.size() == 4) emit_word(full, edge_no, done);
    endtask

    task automatic step(input logic en, input logic valid, input logic [31:0] d,
                        input logic flush, input logic full);
        bit done;
        capture_en    = en;
        sample_valid  = valid;
        sample_data   = d;
        capture_flush = flush;
        fifo_full     = full;
        @(posedge clk_312p5mhz);
        edge_no++;
        case (phase)
            0: if (en) begin
                phase = 1;
                if (valid) accept(d, full);
            end
            1: begin
                if (en && valid) accept(d, full);
                if (flush) phase = 2;
            end
            2: begin
                done = 1'b0;
                if (pend.size() > 0) emit_word(full, edge_no, done);
                exp_fd.push_back({16'(edge_no), 15'd0, done});
                phase = 3;
            end
            default: if (!en) phase = 0;
        endcase
        #1;
    endtask

    task automatic do_reset();
        trig_rst      = 1'b1;
        capture_en    = 1'($urandom);
        sample_valid  = 1'($urandom);
        sample_data   = $urandom;
        capture_flush = 1'($urandom);
        fifo_full     = 1'($urandom);
        @(posedge clk_312p5mhz);
        edge_no++;
        #1;
        trig_rst  = 1'b0;
        phase     = 0;
        pend.delete();
        exp_count = '0;
        exp_ovf   = 1'b0;
        have_last = 1'b0;
        check("reset_outputs",
              {fifo_wr_en, fifo_wr_data, fifo_wr_lanes, flush_done, overflow, sample_count}, '0);
    endtask

    task automatic idle(input int n, input logic en);
        for (int i = 0; i < n; i++) step(en, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic check_scenario();
        int n;
        check("num_writes", got_wr.size(), exp_wr.size());
        n = (got_wr.size() < exp_wr.size()) ? got_wr.size() : exp_wr.size();
        for (int i = 0; i < n; i++) check("write", got_wr[i], exp_wr[i]);
        check("num_flush_done", got_fd.size(), exp_fd.size());
        n = (got_fd.size() < exp_fd.size()) ? got_fd.size() : exp_fd.size();
        for (int i = 0; i < n; i++) check("flush_done", got_fd[i], exp_fd[i]);
        check("sample_count", sample_count, exp_count);
        check("overflow", overflow, exp_ovf);
        if (have_last) check("data_hold", fifo_wr_data, last_data);
        got_wr.delete();
        exp_wr.delete();
        got_fd.delete();
        exp_fd.delete();
    endtask

    initial begin
        int sent;
        int guard;
        logic en;
        logic valid;
        trig_rst = 1'b1;
        capture_en = 1'b0;
        sample_valid = 1'b0;
        sample_data = '0;
        capture_flush = 1'b0;
        fifo_full = 1'b0;
        phase = 0;
        exp_count = '0;
        exp_ovf = 1'b0;
        have_last = 1'b0;

        // Pack order
        do_reset();
        step(1, 1, 32'h1111_1111, 0, 0);
        step(1, 1, 32'h2222_2222, 0, 0);
        step(1, 1, 32'h3333_3333, 0, 0);
        step(1, 1, 32'h4444_4444, 0, 0);
        idle(4, 1'b1);
        check("pack_order_data", fifo_wr_data, 128'h44444444_33333333_22222222_11111111);
        check("pack_order_count", sample_count, 32'd4);
        check_scenario();

        // Partial flush
        do_reset();
        for (int i = 0; i < 6; i++) step(1, 1, {4{4'hA + 4'(i)}} << 0 | 32'(i), 0, 0);
        idle(2, 1'b0);
        step(0, 0, 32'd0, 1, 0);
        idle(4, 1'b0);
        check("partial_lanes", fifo_wr_lanes, 3'd2);
        check("partial_upper_zero", fifo_wr_data[127:64], 64'd0);
        check("partial_count", sample_count, 32'd6);
        check_scenario();

        // Empty flush
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, $urandom, 0, 0);
        step(1, 0, 32'd0, 1, 0);
        idle(4, 1'b0);
        check("empty_flush_count", sample_count, 32'd4);
        check_scenario();

        // Overflow: second word completes while full
        do_reset();
        for (int i = 0; i < 12; i++) step(1, 1, $urandom, 0, (i >= 4 && i < 8));
        idle(3, 1'b1);
        check("overflow_set", overflow, 1'b1);
        check("overflow_count", sample_count, 32'd8);
        idle(5, 1'b0);
        check("overflow_sticky", overflow, 1'b1);
        check_scenario();

        // Simultaneous completing sample and flush
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 1, $urandom, 0, 0);
        step(1, 1, $urandom, 1, 0);
        idle(4, 1'b0);
        check_scenario();

        // Mid-capture reset
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 1, $urandom, 0, 0);
        check_scenario();
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, 32'hC0DE_0000 | 32'(i), 0, 0);
        idle(4, 1'b1);
        check("post_reset_data", fifo_wr_data, 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000);
        check_scenario();

        // Randomized captures
        for (int s = 0; s < 30; s++) begin
            do_reset();
            step(0, 1'($urandom), $urandom, 1, 0);
            sent  = 0;
            guard = 0;
            while (sent < int'($urandom_range(13, 0)) && guard < 60) begin
                en    = ($urandom_range(7, 0) != 0);
                valid = ($urandom_range(3, 0) != 0);
                step(en, valid, $urandom, 0, ($urandom_range(3, 0) == 0));
                if (en && valid) sent++;
                guard++;
            end
            if ($urandom_range(1, 0) == 1) step(1, 1, $urandom, 1, 1'($urandom));
            else step(1'($urandom), 0, $urandom, 1, 1'($urandom));
            for (int k = 0; k < int'($urandom_range(3, 1)); k++)
                step(1, 1, $urandom, 1'($urandom), 1'($urandom));
            idle(4, 1'b0);
            check_scenario();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
